// File: rtl/alu_seq.sv
// Registered ALU: single-cycle ops answer one cycle after accept, MUL answers WIDTH cycles after accept.
// Accepts only when idle and the held result is free or being taken; the result is held until out_ready.
module alu_seq #(
  parameter int WIDTH     = 32,
  parameter int IMM_WIDTH = 16,
  parameter int OPW       = 7
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPW-1:0]       op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [IMM_WIDTH-1:0] imm,
  input  logic [WIDTH-1:0]     target,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     result,
  output logic                 carry,
  output logic                 flag,
  output logic                 addr_chg,
  output logic [WIDTH-1:0]     next_addr,
  output logic                 busy
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [OPW-1:0] OP_ADD    = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB    = OPW'(1);
  localparam logic [OPW-1:0] OP_SHL    = OPW'(2);
  localparam logic [OPW-1:0] OP_SHR    = OPW'(3);
  localparam logic [OPW-1:0] OP_PASS   = OPW'(4);
  localparam logic [OPW-1:0] OP_LOADLO = OPW'(5);
  localparam logic [OPW-1:0] OP_LOADHI = OPW'(6);
  localparam logic [OPW-1:0] OP_EQ     = OPW'(8);
  localparam logic [OPW-1:0] OP_LTU    = OPW'(9);
  localparam logic [OPW-1:0] OP_GTU    = OPW'(10);
  localparam logic [OPW-1:0] OP_MUL    = OPW'(11);
  localparam logic [OPW-1:0] OP_JMP    = OPW'(14);
  localparam logic [OPW-1:0] OP_BRF    = OPW'(15);
  localparam logic [OPW-1:0] OP_NOTF   = OPW'(16);

  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc, mcand, mplier, acc_step;
  logic [CW-1:0]    cnt;
  logic             accept;

  logic [WIDTH-1:0] c_res, c_na;
  logic             c_carry, c_flag, c_ac;

  assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign acc_step = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    c_res   = '0;
    c_carry = carry;
    c_flag  = flag;
    c_ac    = 1'b0;
    c_na    = '0;
    case (op)
      OP_ADD:    {c_carry, c_res} = {1'b0, a} + {1'b0, b};
      OP_SUB:    {c_carry, c_res} = {1'b0, a} - {1'b0, b};
      OP_SHL:    c_res = (b >= WIDTH'(WIDTH)) ? '0 : (a << b);
      OP_SHR:    c_res = (b >= WIDTH'(WIDTH)) ? '0 : (a >> b);
      OP_PASS:   c_res = a;
      OP_LOADLO: c_res = {a[WIDTH-1:IMM_WIDTH], imm};
      OP_LOADHI: c_res = {imm, a[WIDTH-IMM_WIDTH-1:0]};
      OP_EQ:     c_flag = (a == b);
      OP_LTU:    c_flag = (a < b);
      OP_GTU:    c_flag = (a > b);
      OP_NOTF:   c_flag = ~flag;
      OP_JMP: begin
        c_ac = 1'b1;
        c_na = target;
      end
      // Branch decision uses the flag as registered before this edge.
      OP_BRF: begin
        c_ac = flag;
        c_na = flag ? target : '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      flag      <= 1'b0;
      addr_chg  <= 1'b0;
      next_addr <= '0;
      busy      <= 1'b0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (op == OP_MUL) begin
              state     <= S_MUL;
              busy      <= 1'b1;
              out_valid <= 1'b0;
              addr_chg  <= 1'b0;
              next_addr <= '0;
              acc       <= '0;
              mcand     <= a;
              mplier    <= b;
              cnt       <= '0;
            end else begin
              out_valid <= 1'b1;
              result    <= c_res;
              carry     <= c_carry;
              flag      <= c_flag;
              addr_chg  <= c_ac;
              next_addr <= c_na;
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        // One multiplier bit per cycle; the last step writes the result directly.
        S_MUL: begin
          acc    <= acc_step;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            result    <= acc_step;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed corner cases then random ops against a behavioural model.
module tb_alu_seq;
  localparam int W  = 32;
  localparam int IW = 16;
  localparam int OW = 7;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [OW-1:0] op;
  logic [W-1:0]  a, b, target, result, next_addr;
  logic [IW-1:0] imm;
  logic          carry, flag, addr_chg, busy;

  int vectors     = 0;
  int miscompares = 0;

  logic m_flag, m_carry;

  alu_seq #(.WIDTH(W), .IMM_WIDTH(IW), .OPW(OW)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .imm(imm), .target(target),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .flag(flag),
    .addr_chg(addr_chg), .next_addr(next_addr), .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_b(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Architectural effect of one operation, in plain arithmetic.
  task automatic model(input logic [OW-1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [IW-1:0] im, input logic [W-1:0] tg,
                       output logic [W-1:0] r, output logic ac, output logic [W-1:0] na);
    logic [63:0] wide;
    r = '0; ac = 1'b0; na = '0;
    case (o)
      0: begin wide = {32'h0, x} + {32'h0, y}; r = wide[31:0]; m_carry = wide[32]; end
      1: begin r = x - y; m_carry = (x < y); end
      2: r = (y >= 32) ? '0 : (x << y);
      3: r = (y >= 32) ? '0 : (x >> y);
      4: r = x;
      5: r = (x & 32'hFFFF_0000) | {16'h0, im};
      6: r = (x & 32'h0000_FFFF) | {im, 16'h0};
      8: m_flag = (x == y);
      9: m_flag = (x < y);
      10: m_flag = (x > y);
      11: begin wide = {32'h0, x} * {32'h0, y}; r = wide[31:0]; end
      14: begin ac = 1'b1; na = tg; end
      15: begin ac = m_flag; na = m_flag ? tg : '0; end
      16: m_flag = !m_flag;
      default: ;
    endcase
  endtask

  task automatic run_op(input string tag, input logic [OW-1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [IW-1:0] im, input logic [W-1:0] tg,
                        input bit stall);
    logic [W-1:0] er, ena;
    logic         eac;
    int           lat;
    lat = 0;
    while (!in_ready && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
    check_b({tag, ":in_ready"}, in_ready, 1'b1);
    op = o; a = x; b = y; imm = im; target = tg; in_valid = 1'b1;
    model(o, x, y, im, tg, er, eac, ena);
    @(posedge clock); #1;
    if (o == 11) begin
      check_b({tag, ":busy"}, busy, 1'b1);
      check_b({tag, ":in_ready_busy"}, in_ready, 1'b0);
      check_b({tag, ":ov_busy"}, out_valid, 1'b0);
      // A carry-producing ADD offered during the multiply must be ignored.
      op = 0; a = '1; b = 1;
      lat = 0;
      while (!out_valid && lat < 3 * W) begin
        @(posedge clock); #1;
        lat++;
      end
      in_valid = 1'b0;
      check({tag, ":mul_latency"}, lat, W);
      check_b({tag, ":busy_done"}, busy, 1'b0);
    end else begin
      in_valid = 1'b0;
    end
    check_b({tag, ":out_valid"}, out_valid, 1'b1);
    check({tag, ":result"}, result, er);
    check_b({tag, ":carry"}, carry, m_carry);
    check_b({tag, ":flag"}, flag, m_flag);
    check_b({tag, ":addr_chg"}, addr_chg, eac);
    check({tag, ":next_addr"}, next_addr, ena);
    if (stall) begin
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(posedge clock); #1;
        check_b({tag, ":hold_ov"}, out_valid, 1'b1);
        check({tag, ":hold_result"}, result, er);
        check_b({tag, ":hold_in_ready"}, in_ready, 1'b0);
      end
      out_ready = 1'b1;
      @(posedge clock); #1;
      check_b({tag, ":drop_ov"}, out_valid, 1'b0);
    end
  endtask

  initial begin
    logic [OW-1:0] rop;
    logic [W-1:0]  rx, ry;
    logic [OW-1:0] ops [17];
    ops = '{0, 1, 2, 3, 4, 5, 6, 8, 9, 10, 11, 14, 15, 16, 7, 12, 100};

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; a = '0; b = '0; imm = '0; target = '0;
    m_flag = 1'b0; m_carry = 1'b0;
    #12;
    check_b("rst:out_valid", out_valid, 1'b0);
    check("rst:result", result, '0);
    check_b("rst:flag", flag, 1'b0);
    check_b("rst:carry", carry, 1'b0);
    check_b("rst:busy", busy, 1'b0);
    check("rst:next_addr", next_addr, '0);
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;

    run_op("add_wrap", 0, 32'hFFFF_FFFF, 32'd1, '0, '0, 0);
    run_op("sub_borrow", 1, 32'd5, 32'd7, '0, '0, 0);
    run_op("shl31", 2, 32'd1, 32'd31, '0, '0, 0);
    run_op("shl32", 2, 32'd1, 32'd32, '0, '0, 0);
    run_op("shr31", 3, 32'h8000_0000, 32'd31, '0, '0, 0);
    run_op("loadlo", 5, 32'h1234_5678, '0, 16'hABCD, '0, 0);
    run_op("loadhi", 6, 32'h1234_5678, '0, 16'hABCD, '0, 0);
    run_op("eq77", 8, 32'd7, 32'd7, '0, '0, 0);
    run_op("brf_taken", 15, '0, '0, '0, 32'd100, 0);
    run_op("ltu93", 9, 32'd9, 32'd3, '0, '0, 0);
    run_op("brf_not", 15, '0, '0, '0, 32'd100, 0);
    run_op("jmp", 14, '0, '0, '0, 32'h0000_4000, 0);
    run_op("notf", 16, '0, '0, '0, '0, 0);
    run_op("pass", 4, 32'hDEAD_BEEF, '0, '0, '0, 1);
    run_op("undef7", 7, 32'h55, 32'h66, '0, 32'h77, 0);
    run_op("mul", 11, 32'd1234, 32'd5678, '0, '0, 1);

    // Reset in the middle of a multiply.
    op = 11; a = 32'd99; b = 32'd77; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check_b("midrst:busy", busy, 1'b0);
    check_b("midrst:out_valid", out_valid, 1'b0);
    check("midrst:result", result, '0);
    check_b("midrst:flag", flag, 1'b0);
    check_b("midrst:carry", carry, 1'b0);
    check_b("midrst:addr_chg", addr_chg, 1'b0);
    check("midrst:next_addr", next_addr, '0);
    m_flag = 1'b0; m_carry = 1'b0;
    @(negedge clock); reset_n = 1'b1;
    repeat (W + 2) @(posedge clock);
    #1;
    check_b("postrst:no_result", out_valid, 1'b0);
    check_b("postrst:in_ready", in_ready, 1'b1);
    run_op("postrst_add", 0, 32'h7FFF_FFFF, 32'h8000_0001, '0, '0, 0);

    for (int i = 0; i < 120; i++) begin
      rop = ops[$urandom_range(0, 16)];
      rx  = $urandom;
      ry  = $urandom;
      if (rop == 2 || rop == 3) ry = $urandom_range(0, 40);
      if (rop == 8 && $urandom_range(0, 1) == 1) ry = rx;
      run_op("rand", rop, rx, ry, 16'($urandom), $urandom, $urandom_range(0, 7) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
